window_3x3: RTL
===============

Name: window_3x3

Overview:
- Downstream neighbour of the line buffer in the streaming image pipeline.
- Each accepted pixel brings three vertically aligned samples: the current row from the input stream, the row above from the first line buffer, and the row two above from the second.
- The block shifts these into a 3x3 register window and tracks pixel column and row.
- It emits a window with valid and centre coordinates only when all nine taps lie inside the frame.
- It feeds the 3x3 kernel stages (filters, edge detection).

Parameters:
WIDTH, 8, bits per pixel
IMG_W, 64, pixels per line (>=3); must equal the line buffer DEPTH
IMG_H, 64, lines per frame (>=3)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
en  in  1  pixel-accept strobe; same signal that drives the line buffers' en
sof  in  1  start of frame; qualified by en; marks the pixel at (col 0, row 0)
row0_in  in  WIDTH  current-row pixel (newest)
row1_in  in  WIDTH  pixel one line above (line buffer 1 output)
row2_in  in  WIDTH  pixel two lines above (line buffer 2 output)
win_out  out  9*WIDTH  window; tap (r,c) at bits [(r*3+c)*WIDTH +: WIDTH]
  - r=0 is the top row (row2), r=2 is the bottom row (row0)
  - c=0 is the oldest (leftmost) column, c=2 is the newest
win_valid  out  1  one-cycle pulse: win_out holds a fully in-frame window
x_pos  out  $clog2(IMG_W)  column of the window centre (tap 1,1)
y_pos  out  $clog2(IMG_H)  row of the window centre
frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted
sof_err  out  1  one-cycle pulse: sof arrived while a frame was in progress

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; col=0, row=0.
  - All window taps, win_out, win_valid, x_pos, y_pos, frame_done, sof_err = 0.
- States:
  - IDLE: en without sof is ignored; no shift, counters hold. en&sof accepts the pixel as (0,0) and moves to ACTIVE.
  - ACTIVE: every en accepts one pixel.
- Accept action (en=1 in ACTIVE, or en&sof in IDLE):
  - Each window row shifts left by one column.
  - row2_in, row1_in, row0_in load into c=2 of r=0, r=1, r=2 respectively.
- Counters, per accepted pixel:
  - col increments; at IMG_W-1, col wraps to 0 and row increments.
- Validity: registered one cycle after the accept.
  - win_valid=1 iff the accepted pixel had col>=2 and row>=2.
  - x_pos = that col-1; y_pos = that row-1.
  - Windows straddling a line wrap (col 0 or 1) hold stale taps from the previous line and are never flagged valid.
  - Rows 0-1 are masked, so line-buffer warm-up contents are never used.
- Latency: pixel accepted at edge N -> win_out/win_valid updated at edge N+1.
- en=0: no shift, no counter change; win_valid and frame_done drop to 0 next edge; win_out holds its value.
- Last pixel (col=IMG_W-1, row=IMG_H-1):
  - Its window is valid as normal.
  - frame_done pulses in the same cycle as that win_valid.
  - col=0, row=0, state returns to IDLE.
- sof with en in ACTIVE (mid-frame):
  - The pixel is accepted as (0,0); counters restart; state stays ACTIVE.
  - sof_err pulses next cycle.
  - No win_valid for that pixel.
- sof with en in ACTIVE exactly on the last pixel: treated as a restart; frame_done is not asserted; sof_err=1.
- Frame totals: exactly (IMG_W-2)*(IMG_H-2) win_valid pulses per complete frame.
- Reset mid-frame: immediate return to reset state; the next frame requires sof.

Test Plan:
Bench setup for all scenarios:
- IMG_W=4, IMG_H=4, WIDTH=8; pixel value = row*16+col.
- The bench models the line buffers: row1_in = value(row-1,col), row2_in = value(row-2,col), 0 when out of frame.

1. One full frame with en held high, sof on the first pixel:
   - win_valid pulses 4 times, one cycle after pixels (2,2),(3,2),(2,3),(3,3).
   - First window: centre 0x11, x_pos=1, y_pos=1; taps r0 = 00,01,02, r2 = 20,21,22.
   - frame_done coincides with the 4th win_valid.
2. Same frame with en toggling 1,0,1,0:
   - Same 4 windows with identical contents; win_valid never high on a cycle following en=0; win_out holds during gaps.
3. Pixels driven before any sof:
   - No shifts, win_valid=0, counters stay 0.
   - A subsequent sof frame behaves exactly as scenario 1.
4. sof reasserted at pixel (1,2):
   - sof_err pulses once; no frame_done for the aborted frame.
   - The restarted frame yields 4 valid windows starting at centre (1,1).
5. rst asserted asynchronously mid-clock at pixel (2,3):
   - All outputs are 0 immediately, without a clock edge.
   - After release, a new sof frame gives 4 correct windows.
6. Two back-to-back frames, sof immediately after the last pixel:
   - 8 win_valid pulses total, 2 frame_done pulses, sof_err never asserted.

Source files
------------

// File: rtl/window_3x3.sv
// 3x3 sliding window over a raster pixel stream fed by two line buffers.
// Tracks pixel column/row and flags windows whose nine taps all lie in-frame.
module window_3x3 #(
  parameter int WIDTH = 8,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       sof,
  input  logic [WIDTH-1:0]           row0_in,
  input  logic [WIDTH-1:0]           row1_in,
  input  logic [WIDTH-1:0]           row2_in,
  output logic [9*WIDTH-1:0]         win_out,
  output logic                       win_valid,
  output logic [$clog2(IMG_W)-1:0]   x_pos,
  output logic [$clog2(IMG_H)-1:0]   y_pos,
  output logic                       frame_done,
  output logic                       sof_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [9*WIDTH-1:0]  taps_q, taps_d;
  logic                win_valid_q, win_valid_d;
  logic [CW-1:0]       x_q, x_d;
  logic [RW-1:0]       y_q, y_d;
  logic                frame_done_q, frame_done_d;
  logic                sof_err_q, sof_err_d;

  logic                accept;
  logic [CW-1:0]       pcol;
  logic [RW-1:0]       prow;
  logic                last_pix;
  logic [WIDTH-1:0]    new_tap [3];

  // sof always relabels the accepted pixel as (0,0), even mid-frame.
  assign accept   = en & (sof | (state_q == ACTIVE));
  assign pcol     = sof ? '0 : col_q;
  assign prow     = sof ? '0 : row_q;
  assign last_pix = (pcol == CW'(IMG_W - 1)) && (prow == RW'(IMG_H - 1));

  always_comb begin
    new_tap[0] = row2_in;
    new_tap[1] = row1_in;
    new_tap[2] = row0_in;
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    taps_d       = taps_q;
    x_d          = x_q;
    y_d          = y_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    sof_err_d    = 1'b0;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        taps_d[(r*3+0)*WIDTH +: WIDTH] = taps_q[(r*3+1)*WIDTH +: WIDTH];
        taps_d[(r*3+1)*WIDTH +: WIDTH] = taps_q[(r*3+2)*WIDTH +: WIDTH];
        taps_d[(r*3+2)*WIDTH +: WIDTH] = new_tap[r];
      end
      sof_err_d = sof & (state_q == ACTIVE);
      // Columns 0-1 hold stale taps from the previous line; rows 0-1 see warm-up data.
      if ((pcol >= CW'(2)) && (prow >= RW'(2))) begin
        win_valid_d = 1'b1;
        x_d         = pcol - CW'(1);
        y_d         = prow - RW'(1);
      end
      if (last_pix) begin
        frame_done_d = 1'b1;
        col_d        = '0;
        row_d        = '0;
        state_d      = IDLE;
      end else begin
        state_d = ACTIVE;
        if (pcol == CW'(IMG_W - 1)) begin
          col_d = '0;
          row_d = prow + RW'(1);
        end else begin
          col_d = pcol + CW'(1);
          row_d = prow;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      taps_q       <= '0;
      win_valid_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      taps_q       <= taps_d;
      win_valid_q  <= win_valid_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_done_q <= frame_done_d;
      sof_err_q    <= sof_err_d;
    end
  end

  assign win_out    = taps_q;
  assign win_valid  = win_valid_q;
  assign x_pos      = x_q;
  assign y_pos      = y_q;
  assign frame_done = frame_done_q;
  assign sof_err    = sof_err_q;

endmodule
